// File: rtl/tff_mod_counter.sv
// Bank of WIDTH T flip-flops: modulo up/down counter with load, wrap/saturate,
// terminal-count pulse and sticky overflow, or a free per-bit toggle bank.
module tff_mod_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] t_vec,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             ovf
);

  // MODULUS may be 2^WIDTH, so the top value itself always fits in WIDTH bits.
  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);
  localparam bit               C_SAT = (SATURATE != 0);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qbar;
  logic             r_tc;
  logic             r_ovf;

  logic             w_at_top;
  logic             w_at_bot;
  logic             w_bound;
  logic [WIDTH-1:0] w_step_q;
  logic [WIDTH-1:0] w_load_q;
  logic [WIDTH-1:0] w_next_q;

  // Values left above C_MAX by a toggle excursion count as the upper bound.
  assign w_at_top = (r_q >= C_MAX);
  assign w_at_bot = (r_q == '0);
  assign w_bound  = en & ~load & ~mode & (up ? w_at_top : w_at_bot);
  assign w_load_q = (!mode && (load_val > C_MAX)) ? C_MAX : load_val;

  always_comb begin
    w_step_q = r_q;
    if (up) begin
      if (w_at_top) w_step_q = C_SAT ? r_q : '0;
      else          w_step_q = r_q + WIDTH'(1);
    end else begin
      if (w_at_bot) w_step_q = C_SAT ? r_q : C_MAX;
      else          w_step_q = r_q - WIDTH'(1);
    end
  end

  always_comb begin
    w_next_q = r_q;
    if (load)      w_next_q = w_load_q;
    else if (en)   w_next_q = mode ? (r_q ^ t_vec) : w_step_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q    <= '0;
      r_qbar <= '1;
      r_tc   <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_q    <= w_next_q;
      r_qbar <= ~w_next_q;
      r_tc   <= w_bound;
      // a boundary event on the same edge as ovf_clr leaves the flag set
      r_ovf  <= w_bound | (r_ovf & ~ovf_clr);
    end
  end

  assign q    = r_q;
  assign qbar = r_qbar;
  assign tc   = r_tc;
  assign ovf  = r_ovf;

endmodule
